// File: rtl/tof_frame_readout_fsm_if.sv
// Control, framebuffer read port and pixel stream of the ToF frame readout.
// abort/aborted are present only when TOF_READOUT_ABORT_EN is defined.
interface tof_frame_readout_fsm_if #(
    parameter int unsigned COORD_W = 8
);
    logic               start_scan;
    logic               busy;
    logic               done;
    logic               rd_en;
    logic [COORD_W-1:0] rd_x;
    logic [COORD_W-1:0] rd_y;
    logic               rd_data;
    logic               pix_valid;
    logic               pix_ready;
    logic               pix_data;
    logic [COORD_W-1:0] pix_x;
    logic [COORD_W-1:0] pix_y;
    logic               pix_sof;
    logic               pix_eol;
    logic               pix_eof;
`ifdef TOF_READOUT_ABORT_EN
    logic               abort;
    logic               aborted;
`endif

    // Readout engine side
    modport master (
`ifdef TOF_READOUT_ABORT_EN
        input  abort,
        output aborted,
`endif
        input  start_scan, rd_data, pix_ready,
        output busy, done, rd_en, rd_x, rd_y,
        output pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof
    );

    // Controller / framebuffer / host side
    modport slave (
`ifdef TOF_READOUT_ABORT_EN
        output abort,
        input  aborted,
`endif
        output start_scan, rd_data, pix_ready,
        input  busy, done, rd_en, rd_x, rd_y,
        input  pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof
    );
endinterface

// File: rtl/tof_frame_readout_fsm.sv
// Raster readout of the 256x256 1-bit ToF framebuffer into a valid/ready pixel stream.
// Optional scan abort is enabled by defining TOF_READOUT_ABORT_EN.
module tof_frame_readout_fsm #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                    clk_sys,
    input  logic                    rst_sys_n,
    tof_frame_readout_fsm_if.master bus
);
    localparam int unsigned COORD_W = ADDR_W / 2;
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned SUM_W   = CNT_W + 1;

    typedef enum logic [1:0] { S_IDLE, S_ISSUE, S_DRAIN } state_t;

    state_t             r_state, w_state_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic [ADDR_W-1:0]  r_addr;

    logic [RD_LAT-1:0]  r_dl_vld;
    logic [COORD_W-1:0] r_dl_x [RD_LAT];
    logic [COORD_W-1:0] r_dl_y [RD_LAT];
    logic [CNT_W-1:0]   w_outstanding;

    logic               r_fifo_d [FIFO_DEPTH];
    logic [COORD_W-1:0] r_fifo_x [FIFO_DEPTH];
    logic [COORD_W-1:0] r_fifo_y [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_start, w_credit, w_issue, w_push, w_pop, w_valid, w_final;
    logic               w_abort_hit, w_discard;
    logic [COORD_W-1:0] w_head_x, w_head_y;

`ifdef TOF_READOUT_ABORT_EN
    logic r_aborting, w_aborting_nxt;
    logic r_aborted,  w_aborted_nxt;

    assign w_abort_hit = bus.abort && r_busy && !r_aborting;
    assign w_discard   = w_abort_hit || r_aborting;
    assign bus.aborted = r_aborted;
`else
    assign w_abort_hit = 1'b0;
    assign w_discard   = 1'b0;
`endif

    // Reads in flight = valid stages of the return delay line
    always_comb begin
        w_outstanding = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_outstanding = w_outstanding + CNT_W'(r_dl_vld[i]);
        end
    end

    // Credit uses the registered count only; a same-cycle pop earns nothing
    assign w_credit = (SUM_W'(r_count) + SUM_W'(w_outstanding)) < SUM_W'(FIFO_DEPTH);
    assign w_start  = (r_state == S_IDLE) && bus.start_scan;
    assign w_issue  = (r_state == S_ISSUE) && w_credit;
    assign w_valid  = (r_count != '0);
    assign w_pop    = w_valid && bus.pix_ready;
    assign w_push   = r_dl_vld[RD_LAT-1] && !w_discard;
    assign w_final  = w_pop && (r_count == CNT_W'(1)) && (w_outstanding == '0);

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef TOF_READOUT_ABORT_EN
            r_aborting <= 1'b0;
            r_aborted  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
`ifdef TOF_READOUT_ABORT_EN
            r_aborting <= w_aborting_nxt;
            r_aborted  <= w_aborted_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
`ifdef TOF_READOUT_ABORT_EN
        w_aborting_nxt = r_aborting;
        w_aborted_nxt  = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_ISSUE;
                    w_busy_nxt  = 1'b1;
                end
            end
            S_ISSUE: begin
`ifdef TOF_READOUT_ABORT_EN
                if (w_abort_hit) begin
                    w_state_nxt    = S_DRAIN;
                    w_aborting_nxt = 1'b1;
                end else
`endif
                if (w_issue && (r_addr == '1)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
`ifdef TOF_READOUT_ABORT_EN
                if (w_abort_hit) begin
                    w_aborting_nxt = 1'b1;
                end else if (r_aborting) begin
                    if (w_outstanding == '0) begin
                        w_state_nxt    = S_IDLE;
                        w_busy_nxt     = 1'b0;
                        w_aborting_nxt = 1'b0;
                        w_aborted_nxt  = 1'b1;
                    end
                end else
`endif
                if (w_final) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Raster address; wraps to 0 naturally on the last issue
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            r_addr <= '0;
        end else if (w_start) begin
            r_addr <= '0;
        end else if (w_issue) begin
            r_addr <= r_addr + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            r_dl_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_dl_x[i] <= '0;
                r_dl_y[i] <= '0;
            end
        end else begin
            r_dl_vld[0] <= w_issue;
            r_dl_x[0]   <= r_addr[COORD_W-1:0];
            r_dl_y[0]   <= r_addr[ADDR_W-1:COORD_W];
            for (int i = 1; i < RD_LAT; i++) begin
                r_dl_vld[i] <= r_dl_vld[i-1];
                r_dl_x[i]   <= r_dl_x[i-1];
                r_dl_y[i]   <= r_dl_y[i-1];
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_abort_hit) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Storage is not reset; everything it feeds is gated by w_valid
    always_ff @(posedge clk_sys) begin
        if (w_push) begin
            r_fifo_d[r_wr_ptr] <= bus.rd_data;
            r_fifo_x[r_wr_ptr] <= r_dl_x[RD_LAT-1];
            r_fifo_y[r_wr_ptr] <= r_dl_y[RD_LAT-1];
        end
    end

    assign w_head_x = w_valid ? r_fifo_x[r_rd_ptr] : '0;
    assign w_head_y = w_valid ? r_fifo_y[r_rd_ptr] : '0;

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.rd_en     = w_issue;
    assign bus.rd_x      = r_addr[COORD_W-1:0];
    assign bus.rd_y      = r_addr[ADDR_W-1:COORD_W];
    assign bus.pix_valid = w_valid;
    assign bus.pix_data  = w_valid && r_fifo_d[r_rd_ptr];
    assign bus.pix_x     = w_head_x;
    assign bus.pix_y     = w_head_y;
    assign bus.pix_sof   = w_valid && (w_head_x == '0) && (w_head_y == '0);
    assign bus.pix_eol   = w_valid && (w_head_x == '1);
    assign bus.pix_eof   = w_valid && (w_head_x == '1) && (w_head_y == '1);
endmodule

// File: tb/tb_tof_frame_readout_fsm.sv
// Directed bench for tof_frame_readout_fsm with a parity-pattern framebuffer model.
// Exercises the abort path as well when TOF_READOUT_ABORT_EN is defined.
module tb_tof_frame_readout_fsm;
    localparam int unsigned RD_LAT     = 1;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int          FRAME      = 65536;

    logic clk_sys = 1'b0;
    logic rst_sys_n;

    tof_frame_readout_fsm_if bus ();

    tof_frame_readout_fsm #(
        .ADDR_W    (16),
        .RD_LAT    (RD_LAT),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_sys  (clk_sys),
        .rst_sys_n(rst_sys_n),
        .bus      (bus)
    );

    always #5 clk_sys = ~clk_sys;

    // Framebuffer content: pixel = parity of x^y, returned RD_LAT cycles after the read
    logic mem_pipe [RD_LAT];
    always @(posedge clk_sys) begin
        mem_pipe[0] <= ^{bus.rd_x, bus.rd_y};
        for (int i = 1; i < RD_LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
    end
    assign bus.rd_data = mem_pipe[RD_LAT-1];

    int n_tests, n_fail;
    int n_rd, n_acc, n_done, exp_idx, cyc, c0, lat, guard;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pix_vec();
        return 64'({bus.pix_data, bus.pix_x, bus.pix_y, bus.pix_sof, bus.pix_eol, bus.pix_eof});
    endfunction

    function automatic logic [63:0] exp_vec(input int idx);
        logic [15:0] a;
        a = 16'(idx);
        return 64'({^a, a[7:0], a[15:8], a == 16'h0000, a[7:0] == 8'hFF, a == 16'hFFFF});
    endfunction

    function automatic logic [63:0] out_vec();
        return 64'({bus.busy, bus.done, bus.rd_en, bus.pix_valid, bus.pix_data,
                    bus.pix_sof, bus.pix_eol, bus.pix_eof,
                    bus.rd_x, bus.rd_y, bus.pix_x, bus.pix_y});
    endfunction

    // One clock: scoreboard the stream head, advance, then check stall hold
    task automatic cycle();
        logic stalled;
        if (bus.rd_en) n_rd++;
        if (bus.pix_valid) begin
            if (exp_idx < FRAME) check("pixel", pix_vec(), exp_vec(exp_idx));
            if (bus.pix_ready) begin
                exp_idx++;
                n_acc++;
            end
        end else begin
            check("markers_idle", 64'({bus.pix_sof, bus.pix_eol, bus.pix_eof}), 64'(0));
        end
        check("credit", 64'((n_rd - n_acc) <= int'(FIFO_DEPTH)), 64'(1));
        stalled = bus.pix_valid && !bus.pix_ready;
        @(posedge clk_sys);
        #1;
        if (stalled) check("hold_valid", 64'(bus.pix_valid), 64'(1));
        if (bus.done) n_done++;
        cyc++;
    endtask

    initial begin
        n_tests = 0; n_fail = 0; n_rd = 0; n_acc = 0; n_done = 0; cyc = 0;
        exp_idx = FRAME;
        rst_sys_n      = 1'b0;
        bus.start_scan = 1'b0;
        bus.pix_ready  = 1'b0;
`ifdef TOF_READOUT_ABORT_EN
        bus.abort = 1'b0;
`endif
        repeat (3) begin @(posedge clk_sys); #1; end
        check("reset_outs", out_vec(), 64'(0));
        rst_sys_n = 1'b1;
        cycle();
        check("idle_after_reset", 64'({bus.busy, bus.rd_en, bus.pix_valid}), 64'(0));

        // Frame A: full frame, pix_ready held high
        n_rd = 0; n_acc = 0; n_done = 0; exp_idx = 0;
        bus.pix_ready  = 1'b1;
        bus.start_scan = 1'b1;
        cycle();
        bus.start_scan = 1'b0;
        check("busy_on_start", 64'({bus.busy, bus.pix_valid}), 64'(2'b10));
        lat = 0;
        while (!bus.pix_valid && lat < 16) begin cycle(); lat++; end
        check("first_latency", 64'(lat), 64'(RD_LAT + 1));
        check("first_sof", 64'({bus.pix_sof, bus.pix_x, bus.pix_y}), 64'({1'b1, 16'h0000}));
        c0 = cyc;
        while (!bus.done && (cyc - c0) < FRAME + 100) cycle();
        check("frame_done", 64'({bus.done, bus.busy}), 64'(2'b10));
        check("one_per_cycle", 64'(cyc - c0), 64'(FRAME));
        check("frame_count", 64'(n_acc), 64'(FRAME));
        check("frame_reads", 64'(n_rd), 64'(FRAME));

        // Frame B: start in the done cycle, random ready, stray start, then reset
        n_rd = 0; n_acc = 0; exp_idx = 0;
        bus.start_scan = 1'b1;
        cycle();
        bus.start_scan = 1'b0;
        check("b2b_start", 64'({bus.busy, bus.done}), 64'(2'b10));
        guard = 0;
        while (n_acc < 1000 && guard < 20000) begin
            bus.pix_ready = 1'($urandom_range(0, 1));
            cycle();
            guard++;
        end
        check("b_progress_1000", 64'(n_acc), 64'(1000));
        bus.start_scan = 1'b1;
        cycle();
        bus.start_scan = 1'b0;
        check("stray_start_busy", 64'(bus.busy), 64'(1));
        guard = 0;
        while (n_acc < 2000 && guard < 20000) begin
            bus.pix_ready = 1'($urandom_range(0, 1));
            cycle();
            guard++;
        end
        check("b_progress_2000", 64'(n_acc), 64'(2000));
        rst_sys_n = 1'b0;
        #1;
        check("async_reset", out_vec(), 64'(0));
        repeat (3) begin
            @(posedge clk_sys); #1;
            check("reset_hold", out_vec(), 64'(0));
        end
        rst_sys_n = 1'b1;
        n_rd = 0; n_acc = 0; n_done = 0; exp_idx = FRAME;
        bus.pix_ready = 1'b1;
        repeat (50) cycle();
        check("no_emit_after_reset", 64'({n_rd[15:0], n_acc[15:0], n_done[15:0]}), 64'(0));
        check("idle_after_release", 64'(bus.busy), 64'(0));

        // Frame C: long backpressure from the start, then resume
        n_rd = 0; n_acc = 0; exp_idx = 0;
        bus.pix_ready  = 1'b0;
        bus.start_scan = 1'b1;
        cycle();
        bus.start_scan = 1'b0;
        repeat (1000) cycle();
        check("stall_reads", 64'(n_rd <= int'(FIFO_DEPTH)), 64'(1));
        check("stall_head", 64'({bus.pix_valid, bus.pix_x, bus.pix_y}), 64'({1'b1, 16'h0000}));
        bus.pix_ready = 1'b1;
        cycle();
        check("resume_next", 64'({bus.pix_valid, bus.pix_x, bus.pix_y}), 64'({1'b1, 8'd1, 8'd0}));
        repeat (300) begin
            bus.pix_ready = 1'($urandom_range(0, 1));
            cycle();
        end

`ifdef TOF_READOUT_ABORT_EN
        begin
            int k, n_ab;
            bus.pix_ready = 1'b1;
            guard = 0;
            while (n_acc < 500 && guard < 2000) begin cycle(); guard++; end
            check("c_progress_500", 64'(n_acc), 64'(500));
            n_done = 0; n_ab = 0;
            bus.abort = 1'b1;
            cycle();
            bus.abort = 1'b0;
            exp_idx = FRAME;
            k = 1;
            while (bus.pix_valid && k < 16) begin cycle(); k++; end
            check("abort_valid_drop", 64'(k <= int'(RD_LAT + 1)), 64'(1));
            repeat (20) begin
                if (bus.aborted) n_ab++;
                cycle();
            end
            check("aborted_once", 64'(n_ab), 64'(1));
            check("abort_no_done", 64'({n_done[15:0], 15'd0, bus.busy}), 64'(0));
            n_rd = 0; n_acc = 0; exp_idx = 0;
            bus.start_scan = 1'b1;
            cycle();
            bus.start_scan = 1'b0;
            repeat (100) cycle();
            check("restart_after_abort", 64'(n_acc > 50), 64'(1));
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
